// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROL with valid/ready on both sides.
// Shift layers are spread LSB-first over STAGES register stages.
module barrel_shifter_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] iBits,
  input  logic [SW-1:0]    shift,
  input  logic [1:0]       mode,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] oBits
);

  localparam int BASE  = SW / STAGES;
  localparam int EXTRA = SW % STAGES;

  localparam logic [1:0] M_LSL = 2'd0;
  localparam logic [1:0] M_LSR = 2'd1;
  localparam logic [1:0] M_ASR = 2'd2;
  localparam logic [1:0] M_ROL = 2'd3;

  function automatic int lo_of(input int k);
    return k * BASE + ((k < EXTRA) ? k : EXTRA);
  endfunction

  function automatic int cnt_of(input int k);
    return BASE + ((k < EXTRA) ? 1 : 0);
  endfunction

  function automatic logic [WIDTH-1:0] layer(
    input logic [WIDTH-1:0] x,
    input int               amt,
    input logic [1:0]       md,
    input logic             sg
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    r    = x;
    unique case (md)
      M_LSL: r = x << amt;
      M_LSR: r = x >> amt;
      M_ASR: r = (x >> amt) | (sg ? ~(ones >> amt) : '0);
      M_ROL: r = (x << amt) | (x >> (WIDTH - amt));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] val_q [STAGES];
  logic [SW-1:0]    sh_q  [STAGES];
  logic [1:0]       md_q  [STAGES];
  logic [STAGES-1:0] sg_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0] a_val [STAGES];
  logic [SW-1:0]    a_sh  [STAGES];
  logic [1:0]       a_md  [STAGES];
  logic [STAGES-1:0] a_sg;
  logic [STAGES-1:0] a_v;
  logic [WIDTH-1:0] nx_val [STAGES];
  logic [STAGES-1:0] ld;

  always_comb begin
    logic [WIDTH-1:0] x;
    logic             down;
    a_val[0] = iBits;
    a_sh[0]  = shift;
    a_md[0]  = mode;
    a_sg[0]  = iBits[WIDTH-1];
    a_v[0]   = i_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_val[k] = val_q[k-1];
      a_sh[k]  = sh_q[k-1];
      a_md[k]  = md_q[k-1];
      a_sg[k]  = sg_q[k-1];
      a_v[k]   = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      x = a_val[k];
      for (int j = 0; j < SW; j++) begin
        if (j >= lo_of(k) && j < lo_of(k) + cnt_of(k) && a_sh[k][j])
          x = layer(x, 1 << j, a_md[k], a_sg[k]);
      end
      nx_val[k] = x;
    end
    // Advance chain runs from the output back to the input.
    down = o_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !v_q[k] || down;
      down  = ld[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      sg_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        val_q[k] <= '0;
        sh_q[k]  <= '0;
        md_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= a_v[k];
          if (a_v[k]) begin
            val_q[k] <= nx_val[k];
            sh_q[k]  <= a_sh[k];
            md_q[k]  <= a_md[k];
            sg_q[k]  <= a_sg[k];
          end
        end
      end
    end
  end

  assign i_ready = ld[0] && !rst;
  assign o_valid = v_q[STAGES-1];
  assign oBits   = val_q[STAGES-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (WIDTH=8, STAGES=2).
// Expected values are hand-computed constants.
module tb_barrel_shifter_pipe;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] iBits;
  logic [2:0] shift;
  logic [1:0] mode;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] oBits;

  int n_cmp = 0;
  int n_bad = 0;

  barrel_shifter_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .iBits(iBits), .shift(shift), .mode(mode),
    .o_valid(o_valid), .o_ready(o_ready),
    .oBits(oBits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    iBits = 8'h00; shift = 3'd0; mode = 2'd0;
    #2;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ovalid got %b want 0", o_valid);
    end
    n_cmp++;
    if (oBits !== 8'h00) begin
      n_bad++; $display("FAIL reset_obits got %h want 00", oBits);
    end
    n_cmp++;
    if (i_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_iready got %b want 0", i_ready);
    end
    tick; tick;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_iready got %b want 1", i_ready);
    end
  endtask

  task automatic test_modes;
    logic [7:0] vb [11];
    logic [2:0] vs [11];
    logic [1:0] vm [11];
    logic [7:0] ve [11];
    vb = '{8'h81, 8'h81, 8'h81, 8'h90, 8'h70, 8'hA5,
           8'hA5, 8'hA5, 8'hA5, 8'h81, 8'h80};
    vs = '{3'd1, 3'd1, 3'd7, 3'd3, 3'd3, 3'd0,
           3'd0, 3'd0, 3'd0, 3'd4, 3'd7};
    vm = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0,
           2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    ve = '{8'h02, 8'h03, 8'h01, 8'hF2, 8'h0E, 8'hA5,
           8'hA5, 8'hA5, 8'hA5, 8'h18, 8'hFF};
    o_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      i_valid = 1'b1; iBits = vb[i]; shift = vs[i]; mode = vm[i];
      #1;
      n_cmp++;
      if (i_ready !== 1'b1) begin
        n_bad++; $display("FAIL vec%0d_iready got %b want 1", i, i_ready);
      end
      @(posedge clk); #1;
      i_valid = 1'b0; iBits = 8'h5A; shift = 3'd5; mode = 2'd1;
      #1;
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++; $display("FAIL vec%0d_early got %b want 0", i, o_valid);
      end
      tick;
      n_cmp++;
      if (o_valid !== 1'b1 || oBits !== ve[i]) begin
        n_bad++;
        $display("FAIL vec%0d_out got v=%b %h want v=1 %h",
                 i, o_valid, oBits, ve[i]);
      end
    end
    tick;
  endtask

  task automatic test_backpressure;
    int acc;
    int idx;
    int ngot;
    logic [7:0] got [8];
    acc = 0; idx = 0; ngot = 0;
    o_ready = 1'b0;
    shift = 3'd1; mode = 2'd0;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'b1; iBits = 8'(idx + 1);
      #1;
      if (i_ready) begin acc++; idx++; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (acc !== 2) begin
      n_bad++; $display("FAIL bp_accepted got %0d want 2", acc);
    end
    #1;
    n_cmp++;
    if (i_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full_iready got %b want 0", i_ready);
    end
    n_cmp++;
    if (o_valid !== 1'b1 || oBits !== 8'h02) begin
      n_bad++;
      $display("FAIL bp_hold got v=%b %h want v=1 02", o_valid, oBits);
    end
    o_ready = 1'b1;
    for (int c = 0; c < 12 && ngot < 4; c++) begin
      i_valid = (idx < 4); iBits = 8'(idx + 1);
      #1;
      if (o_valid) begin got[ngot] = oBits; ngot++; end
      if (i_valid && i_ready) idx++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    n_cmp++;
    if (ngot !== 4) begin
      n_bad++; $display("FAIL bp_count got %0d want 4", ngot);
    end
    for (int i = 0; i < ngot && i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 8'((i + 1) * 2)) begin
        n_bad++;
        $display("FAIL bp_order%0d got %h want %h",
                 i, got[i], 8'((i + 1) * 2));
      end
    end
    tick; tick;
  endtask

  task automatic test_back_to_back;
    int nrdy_low;
    int acc;
    int ngot;
    int nwrong;
    nrdy_low = 0; acc = 0; ngot = 0; nwrong = 0;
    o_ready = 1'b1; shift = 3'd1; mode = 2'd3;
    for (int c = 0; c < 16; c++) begin
      i_valid = (acc < 10);
      iBits = 8'h80 + 8'(acc + 1);
      #1;
      if (i_valid && !i_ready) nrdy_low++;
      if (o_valid) begin
        ngot++;
        if (oBits !== 8'(2 * ngot + 1)) begin
          nwrong++;
          $display("FAIL b2b_data%0d got %h want %h",
                   ngot, oBits, 8'(2 * ngot + 1));
        end
      end
      if (i_valid && i_ready) acc++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    n_cmp++;
    if (nrdy_low !== 0) begin
      n_bad++; $display("FAIL b2b_iready_low got %0d want 0", nrdy_low);
    end
    n_cmp++;
    if (acc !== 10) begin
      n_bad++; $display("FAIL b2b_accepted got %0d want 10", acc);
    end
    n_cmp++;
    if (ngot !== 10 || nwrong !== 0) begin
      n_bad++;
      $display("FAIL b2b_outputs got %0d (%0d wrong) want 10 (0 wrong)",
               ngot, nwrong);
    end
  endtask

  task automatic test_reset_midop;
    int ngot;
    logic [7:0] first;
    ngot = 0; first = 8'h00;
    o_ready = 1'b0; shift = 3'd2; mode = 2'd0;
    for (int c = 0; c < 2; c++) begin
      i_valid = 1'b1; iBits = 8'h0F + 8'(c);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || oBits !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_clear got v=%b %h want v=0 00", o_valid, oBits);
    end
    tick;
    rst = 1'b0; o_ready = 1'b1;
    i_valid = 1'b1; iBits = 8'h11; shift = 3'd1; mode = 2'd0;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_iready got %b want 1", i_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (o_valid) begin
        if (ngot == 0) first = oBits;
        ngot++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ngot !== 1 || first !== 8'h22) begin
      n_bad++;
      $display("FAIL midrst_after got %0d outs first=%h want 1 outs 22",
               ngot, first);
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_backpressure;
    test_back_to_back;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
